// File: rtl/led7_scan.sv
// led7_scan: multiplexed 8-digit 7-segment scanner with a
// one-deep pending buffer that is applied only at frame boundaries.
// Parameter: P_DIV - clock cycles each digit stays lit (2..2^20).
// Ports:
//   i_w_clk, i_w_rst_n (async active-low)
//   i_w_data[31:0]/i_w_valid/o_w_ready - display data handshake
//   i_w_mask[7:0] - per-digit enable (0 = dark)
//   o_w_digit[3:0] - nibble of the lit digit (registered)
//   o_w_an[7:0]    - active-low one-hot anodes (registered)
//   o_w_frame      - one-cycle pulse after digit 7's slot ends
// Macro LED7_SCAN_BLANK_EN: leading-zero blanking (digit 0 never).
module led7_scan #(
  parameter int P_DIV = 100000
) (
  input  logic        i_w_clk,
  input  logic        i_w_rst_n,
  input  logic [31:0] i_w_data,
  input  logic        i_w_valid,
  output logic        o_w_ready,
  input  logic [7:0]  i_w_mask,
  output logic [3:0]  o_w_digit,
  output logic [7:0]  o_w_an,
  output logic        o_w_frame
);

  localparam int W = $clog2(P_DIV);
  localparam logic [W-1:0] C_LAST = W'(P_DIV - 1);

  logic [W-1:0] r_cnt;
  logic [2:0]   r_idx;
  logic [31:0]  r_disp;
  logic [31:0]  r_pend;
  logic         r_full;

  logic         w_tick;
  logic         w_bnd;
  logic         w_acc;
  logic [3:0]   w_nib;
  logic [7:0]   w_blank;
  logic         w_on;
  logic [7:0]   w_an;

  assign w_tick    = (r_cnt == C_LAST);
  assign w_bnd     = w_tick & (r_idx == 3'd7);
  assign w_acc     = i_w_valid & ~r_full;
  assign o_w_ready = ~r_full;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // A full pending register blocks accepts, so a boundary
  // either drains it or (when empty) may capture new data,
  // which then waits for the next boundary.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      r_disp <= '0;
      r_pend <= '0;
      r_full <= 1'b0;
    end else if (w_bnd && r_full) begin
      r_disp <= r_pend;
      r_full <= 1'b0;
    end else if (w_acc) begin
      r_pend <= i_w_data;
      r_full <= 1'b1;
    end
  end

  assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

`ifdef LED7_SCAN_BLANK_EN
  // Digit k is blank when it and every higher nibble is zero.
  always_comb begin
    w_blank    = '0;
    w_blank[7] = (r_disp[31:28] == 4'd0);
    for (int k = 6; k >= 1; k--) begin
      w_blank[k] = w_blank[k+1] &
                   (r_disp[4*k +: 4] == 4'd0);
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_on = i_w_mask[r_idx] & ~w_blank[r_idx];
  assign w_an = w_on ? ~(8'd1 << r_idx) : 8'hFF;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      o_w_digit <= 4'd0;
      o_w_an    <= 8'hFF;
      o_w_frame <= 1'b0;
    end else begin
      o_w_digit <= w_nib;
      o_w_an    <= w_an;
      o_w_frame <= w_bnd;
    end
  end

endmodule
